// File: rtl/vga_pixel_writer.sv
// vga_pixel_writer: read-modify-write pixel engine for a ROWS x COLS, 1 bit per
// pixel framebuffer stored one row per RAM word (bit x = column x, bit 0 leftmost).
// Pixel ops read the row, patch one bit and write it back; out-of-range ops
// are consumed with a one-cycle err_range pulse and no RAM access.
// Optional clear-screen (op 11) support: define PIXEL_WRITER_CLEAR_EN.
// Without it, op 11 is rejected like an out-of-range command.
module vga_pixel_writer #(
  parameter int ROWS = 480,
  parameter int COLS = 480
) (
  input  logic            clk_50,
  input  logic            rst,
  input  logic            cmd_valid,
  output logic            cmd_ready,
  input  logic [1:0]      cmd_op,
  input  logic [8:0]      cmd_x,
  input  logic [8:0]      cmd_y,
  output logic            ram_480_480_write,
  output logic [8:0]      ram_480_480_address_rw,
  output logic [COLS-1:0] ram_480_480_din,
  input  logic [COLS-1:0] ram_480_480_dout_rw,
  output logic            busy,
  output logic            err_range
);

  localparam logic [9:0] LP_COLS     = 10'(COLS);
  localparam logic [9:0] LP_ROWS     = 10'(ROWS);
  localparam logic [8:0] LP_LAST_ROW = 9'(ROWS - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_RD,
    S_CAP,
    S_WR
`ifdef PIXEL_WRITER_CLEAR_EN
    , S_CLR
`endif
  } state_t;

  state_t            r_state;
  state_t            w_next;
  logic [8:0]        r_addr;
  logic [COLS-1:0]   r_din;
  logic [1:0]        r_op;
  logic [8:0]        r_x;
  logic              r_err;

  logic              w_accept;
  logic              w_is_clr;
  logic              w_in_range;
  logic              w_start_px;
  logic              w_reject;
  logic              w_wr_state;
  logic [COLS-1:0]   w_mod_row;
`ifdef PIXEL_WRITER_CLEAR_EN
  logic              w_start_clr;
`endif

  assign cmd_ready  = (r_state == S_IDLE);
  assign busy       = (r_state != S_IDLE);
  assign w_accept   = cmd_valid && cmd_ready;
  assign w_is_clr   = (cmd_op == 2'b11);
  assign w_in_range = ({1'b0, cmd_x} < LP_COLS) && ({1'b0, cmd_y} < LP_ROWS);
  assign w_start_px = w_accept && !w_is_clr && w_in_range;

`ifdef PIXEL_WRITER_CLEAR_EN
  assign w_start_clr = w_accept && w_is_clr;
  assign w_reject    = w_accept && !w_is_clr && !w_in_range;
  assign w_wr_state  = (r_state == S_WR) || (r_state == S_CLR);
`else
  assign w_reject    = w_accept && (w_is_clr || !w_in_range);
  assign w_wr_state  = (r_state == S_WR);
`endif

  // Write strobe is masked by rst so an abort cannot commit the row being
  // written in the very cycle reset is applied.
  assign ram_480_480_write      = w_wr_state && !rst;
  assign ram_480_480_address_rw = r_addr;
  assign ram_480_480_din        = r_din;
  assign err_range              = r_err;

  // State register
  always_ff @(posedge clk_50) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_next;
  end

  // Next-state logic
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE: begin
        if (w_start_px) w_next = S_RD;
`ifdef PIXEL_WRITER_CLEAR_EN
        else if (w_start_clr) w_next = S_CLR;
`endif
      end
      S_RD:  w_next = S_CAP;
      S_CAP: w_next = S_WR;
      S_WR:  w_next = S_IDLE;
`ifdef PIXEL_WRITER_CLEAR_EN
      S_CLR: if (r_addr == LP_LAST_ROW) w_next = S_IDLE;
`endif
      default: w_next = S_IDLE;
    endcase
  end

  // Patched row: read data with the latched column set, cleared or inverted
  always_comb begin
    w_mod_row = ram_480_480_dout_rw;
    case (r_op)
      2'b00:   w_mod_row[r_x] = 1'b1;
      2'b01:   w_mod_row[r_x] = 1'b0;
      default: w_mod_row[r_x] = ~ram_480_480_dout_rw[r_x];
    endcase
  end

  // Datapath: command latch, row address, write data and error pulse
  always_ff @(posedge clk_50) begin
    if (rst) begin
      r_addr <= '0;
      r_din  <= '0;
      r_op   <= '0;
      r_x    <= '0;
      r_err  <= 1'b0;
    end else begin
      r_err <= w_reject;
      case (r_state)
        S_IDLE: begin
          if (w_start_px) begin
            r_addr <= cmd_y;
            r_op   <= cmd_op;
            r_x    <= cmd_x;
          end
`ifdef PIXEL_WRITER_CLEAR_EN
          else if (w_start_clr) begin
            r_addr <= '0;
            r_din  <= '0;
          end
`endif
        end
        S_CAP: r_din <= w_mod_row;
`ifdef PIXEL_WRITER_CLEAR_EN
        S_CLR: r_addr <= (r_addr == LP_LAST_ROW) ? '0 : r_addr + 9'd1;
`endif
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_vga_pixel_writer.sv
// Testbench for vga_pixel_writer: behavioural framebuffer RAM plus a pixel-level
// reference model (exp_fb) updated from the command semantics.
// Clear-screen scenarios follow PIXEL_WRITER_CLEAR_EN.
module tb_vga_pixel_writer;

  localparam int ROWS = 480;
  localparam int COLS = 480;

  logic            clk_50 = 1'b0;
  logic            rst;
  logic            cmd_valid;
  logic            cmd_ready;
  logic [1:0]      cmd_op;
  logic [8:0]      cmd_x;
  logic [8:0]      cmd_y;
  logic            ram_480_480_write;
  logic [8:0]      ram_480_480_address_rw;
  logic [COLS-1:0] ram_480_480_din;
  logic [COLS-1:0] ram_480_480_dout_rw;
  logic            busy;
  logic            err_range;

  int n_pass  = 0;
  int n_total = 0;

  // RAM contents and preload controls
  logic [COLS-1:0] mem    [ROWS];
  logic [COLS-1:0] exp_fb [ROWS];
  logic            pl_en;
  logic            pl_zero;
  logic [8:0]      pl_row;
  logic [COLS-1:0] pl_data;

  // Observation records of the last run_cmd
  int              wr_k_q[$];
  logic [8:0]      wr_a_q[$];
  logic [COLS-1:0] wr_d_q[$];
  int              n_err;
  int              err_k;
  int              rdy_k;

  always #10 clk_50 = ~clk_50;

  vga_pixel_writer #(.ROWS(ROWS), .COLS(COLS)) dut (
    .clk_50                 (clk_50),
    .rst                    (rst),
    .cmd_valid              (cmd_valid),
    .cmd_ready              (cmd_ready),
    .cmd_op                 (cmd_op),
    .cmd_x                  (cmd_x),
    .cmd_y                  (cmd_y),
    .ram_480_480_write      (ram_480_480_write),
    .ram_480_480_address_rw (ram_480_480_address_rw),
    .ram_480_480_din        (ram_480_480_din),
    .ram_480_480_dout_rw    (ram_480_480_dout_rw),
    .busy                   (busy),
    .err_range              (err_range)
  );

  // Synchronous framebuffer RAM, one-cycle read latency
  always @(posedge clk_50) begin
    if (pl_zero) begin
      for (int i = 0; i < ROWS; i++) mem[i] <= '0;
    end else if (pl_en) begin
      mem[pl_row] <= pl_data;
    end else if (ram_480_480_write && ram_480_480_address_rw < 9'(ROWS)) begin
      mem[ram_480_480_address_rw] <= ram_480_480_din;
    end
    ram_480_480_dout_rw <= (ram_480_480_address_rw < 9'(ROWS)) ? mem[ram_480_480_address_rw] : '0;
  end

  initial begin
    #10_000_000;
    $display("FAIL watchdog: simulation still running at %0t, required to finish earlier", $time);
    $fatal(1, "watchdog expired");
  end

  function automatic logic [COLS-1:0] rand_row();
    logic [COLS-1:0] r;
    r = '0;
    for (int i = 0; i < COLS / 32; i++) r[i*32 +: 32] = $urandom;
    return r;
  endfunction

  // Reference model: apply a pixel op to the expected framebuffer, return the new row
  function automatic logic [COLS-1:0] model_pixel(input int op, input int x, input int y);
    logic [COLS-1:0] row;
    row = exp_fb[y];
    if (op == 0)      row[x] = 1'b1;
    else if (op == 1) row[x] = 1'b0;
    else              row[x] = ~row[x];
    exp_fb[y] = row;
    return row;
  endfunction

  task automatic preload(input int row, input logic [COLS-1:0] data);
    pl_en = 1'b1; pl_row = 9'(row); pl_data = data;
    @(negedge clk_50);
    pl_en = 1'b0;
    exp_fb[row] = data;
  endtask

  task automatic zero_fb();
    pl_zero = 1'b1;
    @(negedge clk_50);
    pl_zero = 1'b0;
    for (int i = 0; i < ROWS; i++) exp_fb[i] = '0;
  endtask

  // Offer one command at the current negedge, then observe cycles N+1.. until ready
  task automatic run_cmd(input logic [1:0] op, input logic [8:0] x, input logic [8:0] y, input int budget);
    wr_k_q.delete(); wr_a_q.delete(); wr_d_q.delete();
    n_err = 0; err_k = -1; rdy_k = -1;
    cmd_op = op; cmd_x = x; cmd_y = y; cmd_valid = 1'b1;
    @(negedge clk_50);
    cmd_valid = 1'b0;
    for (int k = 1; k <= budget; k++) begin
      if (ram_480_480_write) begin
        wr_k_q.push_back(k); wr_a_q.push_back(ram_480_480_address_rw); wr_d_q.push_back(ram_480_480_din);
      end
      if (err_range) begin
        n_err++;
        if (err_k < 0) err_k = k;
      end
      if (cmd_ready) begin
        rdy_k = k;
        break;
      end
      @(negedge clk_50);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; cmd_valid = 1'b1; cmd_op = 2'b00; cmd_x = 9'd3; cmd_y = 9'd4;
    repeat (2) @(negedge clk_50);
    cmd_x = 9'd500;
    @(negedge clk_50);
    n_total++; if (cmd_ready !== 1'b1) $display("FAIL reset_ready: got %b want 1", cmd_ready); else n_pass++;
    n_total++; if (busy !== 1'b0) $display("FAIL reset_busy: got %b want 0", busy); else n_pass++;
    n_total++; if (ram_480_480_write !== 1'b0) $display("FAIL reset_write: got %b want 0", ram_480_480_write); else n_pass++;
    n_total++; if (err_range !== 1'b0) $display("FAIL reset_err: got %b want 0", err_range); else n_pass++;
    n_total++; if (ram_480_480_address_rw !== 9'd0) $display("FAIL reset_addr: got %0d want 0", ram_480_480_address_rw); else n_pass++;
    n_total++; if (ram_480_480_din !== '0) $display("FAIL reset_din: got %h want 0", ram_480_480_din); else n_pass++;
    rst = 1'b0; cmd_valid = 1'b0;
    @(negedge clk_50);
    n_total++; if (busy !== 1'b0 || err_range !== 1'b0)
      $display("FAIL reset_priority: got busy=%b err=%b want busy=0 err=0", busy, err_range); else n_pass++;
  endtask

  task automatic test_set_pixel();
    logic [COLS-1:0] e;
    preload(5, '0);
    e = model_pixel(0, 0, 5);
    run_cmd(2'b00, 9'd0, 9'd5, 10);
    n_total++; if (wr_k_q.size() !== 1) $display("FAIL set_nwrites: got %0d want 1", wr_k_q.size()); else n_pass++;
    if (wr_k_q.size() > 0) begin
      n_total++; if (wr_k_q[0] !== 3) $display("FAIL set_latency: got cycle N+%0d want N+3", wr_k_q[0]); else n_pass++;
      n_total++; if (wr_a_q[0] !== 9'd5) $display("FAIL set_addr: got %0d want 5", wr_a_q[0]); else n_pass++;
      n_total++; if (wr_d_q[0] !== e) $display("FAIL set_din: got %h want %h", wr_d_q[0], e); else n_pass++;
    end
    n_total++; if (rdy_k !== 4) $display("FAIL set_ready: got cycle N+%0d want N+4", rdy_k); else n_pass++;
  endtask

  task automatic test_toggle_twice();
    logic [COLS-1:0] r;
    logic [COLS-1:0] e;
    r = rand_row();
    r[479] = 1'b1;
    preload(100, r);
    for (int unsigned i = 0; i < 2; i++) begin
      e = model_pixel(2, 479, 100);
      run_cmd(2'b10, 9'd479, 9'd100, 10);
      n_total++;
      if (wr_k_q.size() !== 1 || wr_a_q[0] !== 9'd100 || wr_d_q[0] !== e)
        $display("FAIL toggle_%0d: got n=%0d din=%h want n=1 addr=100 din=%h", i, wr_k_q.size(),
                 (wr_d_q.size() > 0) ? wr_d_q[0] : '0, e);
      else n_pass++;
    end
    n_total++; if (exp_fb[100] !== r) $display("FAIL toggle_restore: got %h want %h", mem[100], r); else n_pass++;
  endtask

  task automatic test_range();
    logic [8:0] xs[3];
    logic [8:0] ys[3];
    xs[0] = 9'd480; ys[0] = 9'd0;
    xs[1] = 9'd0;   ys[1] = 9'd480;
    xs[2] = 9'(480 + $urandom_range(0, 31)); ys[2] = 9'(480 + $urandom_range(0, 31));
    for (int unsigned i = 0; i < 3; i++) begin
      run_cmd(2'(i), xs[i], ys[i], 10);
      n_total++;
      if (n_err !== 1 || err_k !== 1 || wr_k_q.size() !== 0 || rdy_k !== 1)
        $display("FAIL range_%0d: got err=%0d@%0d writes=%0d ready@%0d want err=1@1 writes=0 ready@1",
                 i, n_err, err_k, wr_k_q.size(), rdy_k);
      else n_pass++;
      @(negedge clk_50);
      n_total++; if (err_range !== 1'b0 || ram_480_480_write !== 1'b0 || busy !== 1'b0)
        $display("FAIL range_pulse_%0d: got err=%b wr=%b busy=%b want 0 0 0", i, err_range, ram_480_480_write, busy);
      else n_pass++;
    end
  endtask

  task automatic test_back_to_back();
    logic [COLS-1:0] e1;
    logic [COLS-1:0] e2;
    int first_rdy;
    int errs;
    int busy5;
    wr_k_q.delete(); wr_a_q.delete(); wr_d_q.delete();
    preload(10, rand_row());
    e1 = model_pixel(0, 1, 10);
    e2 = model_pixel(2, 1, 10);
    first_rdy = -1; errs = 0; busy5 = -1;
    cmd_op = 2'b00; cmd_x = 9'd1; cmd_y = 9'd10; cmd_valid = 1'b1;
    @(negedge clk_50);
    cmd_op = 2'b10;
    for (int k = 1; k <= 12; k++) begin
      if (ram_480_480_write) begin
        wr_k_q.push_back(k); wr_a_q.push_back(ram_480_480_address_rw); wr_d_q.push_back(ram_480_480_din);
      end
      if (err_range) errs++;
      if (cmd_ready && first_rdy < 0) first_rdy = k;
      if (k == 5) begin
        busy5 = int'(busy);
        cmd_valid = 1'b0;
      end
      @(negedge clk_50);
    end
    n_total++; if (first_rdy !== 4) $display("FAIL b2b_ready: got N+%0d want N+4", first_rdy); else n_pass++;
    n_total++; if (busy5 !== 1) $display("FAIL b2b_accept: got busy=%0d at N+5 want 1", busy5); else n_pass++;
    n_total++; if (wr_k_q.size() !== 2 || errs !== 0)
      $display("FAIL b2b_count: got writes=%0d errs=%0d want writes=2 errs=0", wr_k_q.size(), errs); else n_pass++;
    if (wr_k_q.size() == 2) begin
      n_total++; if (wr_k_q[0] !== 3 || wr_k_q[1] !== 7)
        $display("FAIL b2b_timing: got N+%0d,N+%0d want N+3,N+7", wr_k_q[0], wr_k_q[1]); else n_pass++;
      n_total++; if (wr_d_q[0] !== e1 || wr_a_q[0] !== 9'd10) $display("FAIL b2b_first: got %h want %h", wr_d_q[0], e1); else n_pass++;
      n_total++; if (wr_d_q[1] !== e2 || wr_a_q[1] !== 9'd10) $display("FAIL b2b_second: got %h want %h", wr_d_q[1], e2); else n_pass++;
    end
  endtask

  task automatic test_random();
    int pool[8];
    int op;
    int x;
    int y;
    logic [COLS-1:0] e;
    pool[0] = 0; pool[1] = 479; pool[2] = 1; pool[3] = 478;
    for (int unsigned i = 4; i < 8; i++) pool[i] = $urandom_range(2, 477);
    for (int unsigned i = 0; i < 8; i++) preload(pool[i], rand_row());
    for (int unsigned i = 0; i < 40; i++) begin
      op = $urandom_range(0, 2);
      x  = $urandom_range(0, 479);
      y  = pool[$urandom_range(0, 7)];
      if ($urandom_range(0, 5) == 0) begin
        if ($urandom_range(0, 1) == 0) x = $urandom_range(480, 511);
        else y = $urandom_range(480, 511);
        run_cmd(2'(op), 9'(x), 9'(y), 10);
        n_total++;
        if (n_err !== 1 || wr_k_q.size() !== 0 || rdy_k !== 1)
          $display("FAIL rand_oor_%0d: got err=%0d writes=%0d ready@%0d want 1 0 1", i, n_err, wr_k_q.size(), rdy_k);
        else n_pass++;
      end else begin
        e = model_pixel(op, x, y);
        run_cmd(2'(op), 9'(x), 9'(y), 10);
        n_total++;
        if (wr_k_q.size() !== 1 || n_err !== 0 || rdy_k !== 4)
          $display("FAIL rand_hs_%0d: got writes=%0d err=%0d ready@%0d want 1 0 4", i, wr_k_q.size(), n_err, rdy_k);
        else n_pass++;
        if (wr_k_q.size() == 1) begin
          n_total++;
          if (wr_k_q[0] !== 3 || wr_a_q[0] !== 9'(y) || wr_d_q[0] !== e)
            $display("FAIL rand_wr_%0d: got N+%0d addr=%0d din=%h want N+3 addr=%0d din=%h", i, wr_k_q[0], wr_a_q[0], wr_d_q[0], y, e);
          else n_pass++;
        end
      end
    end
  endtask

  task automatic test_reset_mid_op();
    int nw;
    preload(7, rand_row());
    cmd_op = 2'b00; cmd_x = 9'($urandom_range(0, 479)); cmd_y = 9'd7; cmd_valid = 1'b1;
    @(negedge clk_50);
    cmd_valid = 1'b0;
    @(negedge clk_50);
    rst = 1'b1;
    @(negedge clk_50);
    n_total++; if (ram_480_480_write !== 1'b0 || busy !== 1'b0)
      $display("FAIL abort_px: got wr=%b busy=%b want 0 0", ram_480_480_write, busy); else n_pass++;
    rst = 1'b0;
    nw = 0;
    repeat (6) begin
      if (ram_480_480_write) nw++;
      @(negedge clk_50);
    end
    n_total++; if (nw !== 0 || mem[7] !== exp_fb[7])
      $display("FAIL abort_px_row: got writes=%0d row=%h want 0 row=%h", nw, mem[7], exp_fb[7]); else n_pass++;
  endtask

  task automatic test_clear();
`ifdef PIXEL_WRITER_CLEAR_EN
    int bad;
    for (int unsigned i = 0; i < 4; i++) preload($urandom_range(0, 479), rand_row());
    run_cmd(2'b11, 9'd511, 9'd511, 600);
    bad = 0;
    for (int i = 0; i < wr_k_q.size(); i++)
      if (wr_k_q[i] !== i + 1 || wr_a_q[i] !== 9'(i) || wr_d_q[i] !== '0) bad++;
    n_total++; if (wr_k_q.size() !== ROWS) $display("FAIL clr_count: got %0d want %0d", wr_k_q.size(), ROWS); else n_pass++;
    n_total++; if (bad !== 0) $display("FAIL clr_seq: got %0d bad write cycles want 0", bad); else n_pass++;
    n_total++; if (n_err !== 0 || rdy_k !== ROWS + 1)
      $display("FAIL clr_end: got err=%0d ready@%0d want 0 %0d", n_err, rdy_k, ROWS + 1); else n_pass++;
    n_total++; if (ram_480_480_address_rw !== 9'd0) $display("FAIL clr_addr: got %0d want 0", ram_480_480_address_rw); else n_pass++;
    for (int i = 0; i < ROWS; i++) exp_fb[i] = '0;
`else
    run_cmd(2'b11, 9'd0, 9'd0, 10);
    n_total++; if (n_err !== 1 || wr_k_q.size() !== 0 || rdy_k !== 1)
      $display("FAIL clr_off: got err=%0d writes=%0d ready@%0d want 1 0 1", n_err, wr_k_q.size(), rdy_k); else n_pass++;
`endif
  endtask

  task automatic test_reset_mid_clear();
`ifdef PIXEL_WRITER_CLEAR_EN
    int bad_lo;
    int bad_hi;
    for (int i = 0; i < ROWS; i++) preload(i, rand_row());
    cmd_op = 2'b11; cmd_x = 9'd0; cmd_y = 9'd0; cmd_valid = 1'b1;
    @(negedge clk_50);
    cmd_valid = 1'b0;
    repeat (200) @(negedge clk_50);
    n_total++; if (ram_480_480_address_rw !== 9'd200)
      $display("FAIL midclr_addr: got %0d want 200", ram_480_480_address_rw); else n_pass++;
    rst = 1'b1;
    @(negedge clk_50);
    n_total++; if (ram_480_480_write !== 1'b0 || busy !== 1'b0)
      $display("FAIL midclr_abort: got wr=%b busy=%b want 0 0", ram_480_480_write, busy); else n_pass++;
    rst = 1'b0;
    repeat (4) @(negedge clk_50);
    for (int i = 0; i < 200; i++) exp_fb[i] = '0;
    bad_lo = 0; bad_hi = 0;
    for (int i = 0; i < ROWS; i++)
      if (mem[i] !== exp_fb[i]) begin
        if (i < 200) bad_lo++;
        else bad_hi++;
      end
    n_total++; if (bad_lo !== 0) $display("FAIL midclr_cleared: got %0d wrong rows in 0..199 want 0", bad_lo); else n_pass++;
    n_total++; if (bad_hi !== 0) $display("FAIL midclr_kept: got %0d changed rows in 200..479 want 0", bad_hi); else n_pass++;
`endif
  endtask

  initial begin
    rst = 1'b1; cmd_valid = 1'b0; cmd_op = 2'b00; cmd_x = '0; cmd_y = '0;
    pl_en = 1'b0; pl_zero = 1'b0; pl_row = '0; pl_data = '0;
    test_reset();
    zero_fb();
    test_set_pixel();
    test_toggle_twice();
    test_range();
    test_back_to_back();
    test_random();
    test_reset_mid_op();
    test_clear();
    test_reset_mid_clear();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/vga_pixel_writer.md
VGA_PIXEL_WRITER -- requirements
Module: vga_pixel_writer

Interface
REQ-001 Parameter ROWS, default 480, number of framebuffer rows; row index width is 9 bits.
REQ-002 Parameter COLS, default 480, pixels per row; the row word width is 480 bits.
REQ-003 Clock and reset: one clock; reset is synchronous and active-high.
REQ-004 clk_50  in  1  sole clock; all state updates on its rising edge.
REQ-005 rst  in  1  synchronous, active-high reset.
REQ-006 cmd_valid  in  1  command offered.
REQ-007 cmd_ready  out  1  block accepts a command this cycle.
REQ-008 cmd_op  in  2  operation: 00 set, 01 clear, 10 toggle, 11 clear screen.
REQ-009 cmd_x  in  9  pixel column.
REQ-010 cmd_y  in  9  pixel row.
REQ-011 ram_480_480_write  out  1  framebuffer port-b write enable.
REQ-012 ram_480_480_address_rw  out  9  framebuffer port-b row address.
REQ-013 ram_480_480_din  out  480  framebuffer port-b write data.
REQ-014 ram_480_480_dout_rw  in  480  framebuffer port-b read data, valid one cycle after the address is sampled.
REQ-015 busy  out  1  high whenever the state is not IDLE.
REQ-016 err_range  out  1  one-cycle pulse for a rejected command.

Function
REQ-017 Handshake: a command is accepted on a rising edge only when cmd_valid=1 and cmd_ready=1; cmd_ready=1 only in IDLE.
REQ-018 FSM states are IDLE, RD, CAP, WR and CLR; there are no other states.
REQ-019 Accepted pixel op with cmd_x<COLS and cmd_y<ROWS: IDLE->RD, latching op and x, and driving address=cmd_y.
REQ-020 RD->CAP unconditionally, so that the RAM samples the address.
REQ-021 In CAP, ram_480_480_dout_rw is valid; on the CAP edge, din is registered as the read row with bit[x] forced to 1 (set), forced to 0 (clear) or inverted (toggle), and the FSM goes to WR.
REQ-022 In WR, write=1 with the same address and din, for exactly one cycle; the FSM then returns to IDLE.
REQ-023 Pixel-op latency: the command is accepted at edge N, write is high in cycle N+3, and cmd_ready is high again in cycle N+4.
REQ-024 Column x maps to bit x of the row word; bit 0 is the leftmost pixel.
REQ-025 Out of range (cmd_x>=COLS or cmd_y>=ROWS, pixel ops only): the command is consumed, err_range pulses in the next cycle, there is no RAM access, and the FSM stays in IDLE.
REQ-026 Clear screen: IDLE->CLR with address=0, din=0 and write=1; address increments each cycle through ROWS-1.
REQ-027 Clear-screen sequence: after the cycle with address=ROWS-1, write drops, address returns to 0 and the FSM returns to IDLE; this is exactly ROWS write cycles.
REQ-028 Clear-screen values of cmd_x and cmd_y are ignored and never raise err_range.
REQ-029 write=0 in IDLE, RD and CAP.
REQ-030 cmd_valid while busy is ignored and leaves no side effects; the same command held stable is taken when cmd_ready returns.
REQ-031 The address counter never exceeds ROWS-1, and no write ever targets a row >= ROWS.

Reset
REQ-032 When rst=1 on a rising edge, the next state is IDLE, write=0, address=0, din=0, err_range=0, busy=0 and cmd_ready=1.
REQ-033 Reset mid-operation (RD/CAP/WR/CLR) aborts the operation: no further write occurs, and a partially cleared screen stays partial.
REQ-034 rst has priority over a simultaneous command; that command is not accepted.

Configuration
REQ-035 Macro PIXEL_WRITER_CLEAR_EN, when defined, includes the CLR state, and op 11 behaves per REQ-026 to REQ-028.
REQ-036 When PIXEL_WRITER_CLEAR_EN is undefined, there is no CLR state and op 11 is rejected exactly as in REQ-025 (err_range pulse, no RAM access).

Verification
REQ-037 Set pixel: framebuffer row 5 = 0, command set x=0 y=5 -> one write at address 5, din bit0=1 and all other bits 0, in cycle N+3.
REQ-038 Toggle twice: row 100 preloaded with bit 479=1, two toggles at x=479 y=100 -> first din bit479=0, second din bit479=1, and other bits are unchanged.
REQ-039 Range check: set x=480 y=0, then x=0 y=480 -> two err_range pulses, ram_480_480_write never high, and cmd_ready back to 1 the next cycle.
REQ-040 Clear screen (macro on): op 11 -> 480 consecutive write cycles at addresses 0..479 with din=0, then IDLE; with the macro off -> err_range pulse and zero writes.
REQ-041 Reset mid-clear: rst asserted while address=200 -> write=0 on the following cycle, and rows 200..479 keep their prior contents.
REQ-042 Back-to-back commands: cmd_valid held high with two queued commands -> the second is accepted exactly at cycle N+4, and no command is dropped or duplicated.
